xmem_arbiter: RTL and testbench

XMEM_ARBITER -- requirements
Module: xmem_arbiter

---
 rtl/xmem_arbiter.sv | 133 +++++++++++++
 tb/tb_xmem_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xmem_arbiter.sv
// rtl/xmem_arbiter.sv - two-master Wishbone classic arbiter with slave-ack watchdog
module xmem_arbiter #(
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [29:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_stb_i,
    input  logic        m0_cyc_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic [29:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_stb_i,
    input  logic        m1_cyc_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [29:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic        s_stb_o,
    output logic        s_cyc_o,
    input  logic        s_ack_i,
    output logic [1:0]  gnt
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] G0   = 2'b01;
    localparam logic [1:0] G1   = 2'b10;
    localparam logic [9:0] TO   = 10'(TIMEOUT);

    logic [1:0] state_q, state_d;
    logic       last_q, last_d;
    logic [9:0] cnt_q, cnt_d;
    logic       abort_q, abort_d;
    logic       cyc_g, stb_g;
    logic       to_hit;

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        cyc_g   = 1'b0;
        stb_g   = 1'b0;
        case (state_q)
            G0: begin
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
                s_sel_o = m0_sel_i;
                s_we_o  = m0_we_i;
                cyc_g   = m0_cyc_i;
                stb_g   = m0_stb_i;
            end
            G1: begin
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
                s_sel_o = m1_sel_i;
                s_we_o  = m1_we_i;
                cyc_g   = m1_cyc_i;
                stb_g   = m1_stb_i;
            end
            default: ;
        endcase
    end

    assign s_cyc_o  = cyc_g;
    assign s_stb_o  = cyc_g & stb_g & ~abort_q;
    assign gnt      = {state_q == G1, state_q == G0};
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    // s_stb_o already excludes the abort cycle, so ack and err are exclusive
    assign m0_ack_o = (state_q == G0) & s_ack_i & s_stb_o;
    assign m1_ack_o = (state_q == G1) & s_ack_i & s_stb_o;
    assign m0_err_o = (state_q == G0) & abort_q;
    assign m1_err_o = (state_q == G1) & abort_q;

    // last_q = 1 means m1 was served most recently, so m0 wins a tie
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) state_d = last_q ? G0 : G1;
                else if (m0_cyc_i)        state_d = G0;
                else if (m1_cyc_i)        state_d = G1;
            end
            G0: begin
                if (!m0_cyc_i) begin
                    last_d  = 1'b0;
                    state_d = m1_cyc_i ? G1 : IDLE;
                end
            end
            G1: begin
                if (!m1_cyc_i) begin
                    last_d  = 1'b1;
                    state_d = m0_cyc_i ? G0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // An ack arriving on the limit cycle wins over the timeout
    assign to_hit  = s_stb_o & ~s_ack_i & (cnt_q == TO);
    assign abort_d = to_hit;
    assign cnt_d   = ((state_d != state_q) || !s_stb_o || s_ack_i || to_hit) ? 10'd0
                                                                            : cnt_q + 10'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= 10'd0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
        end
    end

endmodule

// File: tb/tb_xmem_arbiter.sv
// tb/tb_xmem_arbiter.sv - self-checking bench for xmem_arbiter
module tb_xmem_arbiter;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [29:0] m0_adr_i, m1_adr_i, s_adr_o;
    logic [31:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
    logic        m0_we_i, m1_we_i, s_we_o;
    logic [3:0]  m0_sel_i, m1_sel_i, s_sel_o;
    logic        m0_stb_i, m1_stb_i, m0_cyc_i, m1_cyc_i;
    logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
    logic        s_stb_o, s_cyc_o, s_ack_i;
    logic [1:0]  gnt;

    int checks = 0;
    int failures = 0;

    xmem_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_we_i(m0_we_i),
        .m0_sel_i(m0_sel_i), .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_ack_o(m0_ack_o),
        .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_we_i(m1_we_i),
        .m1_sel_i(m1_sel_i), .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_ack_o(m1_ack_o),
        .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_we_o(s_we_o),
        .s_sel_o(s_sel_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_ack_i(s_ack_i),
        .gnt(gnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       c0, c1, s0, s1, ack;
        logic [1:0] gnt;
        logic       scyc, sstb, a0, a1;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        m0_adr_i = '0; m0_dat_i = '0; m0_we_i = 0; m0_sel_i = '0; m0_stb_i = 0; m0_cyc_i = 0;
        m1_adr_i = '0; m1_dat_i = '0; m1_we_i = 0; m1_sel_i = '0; m1_stb_i = 0; m1_cyc_i = 0;
        s_dat_i = '0; s_ack_i = 0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst_n = 1'b0;
        #1;
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_scyc", s_cyc_o, 0);
        chk("rst_sstb", s_stb_o, 0);
        chk("rst_swe", s_we_o, 0);
        chk("rst_ackerr", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 4'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Reference model: owner -1/0/1, last served master, wait count, pending abort
    int  own, lst, wc;
    bit  ab;

    task automatic model_cycle;
        bit c[2], s[2];
        bit scyc, sstb, hit;
        int nown;
        c[0] = m0_cyc_i; c[1] = m1_cyc_i; s[0] = m0_stb_i; s[1] = m1_stb_i;
        scyc = (own >= 0) && c[own];
        sstb = scyc && s[own] && !ab;
        chk("rnd_gnt", gnt, (own < 0) ? 2'b00 : (2'b01 << own));
        chk("rnd_scyc", s_cyc_o, scyc);
        chk("rnd_sstb", s_stb_o, sstb);
        chk("rnd_ack", {m1_ack_o, m0_ack_o},
            {own == 1 && s_ack_i && sstb, own == 0 && s_ack_i && sstb});
        chk("rnd_err", {m1_err_o, m0_err_o}, {own == 1 && ab, own == 0 && ab});
        chk("rnd_bcast", {m0_dat_o ^ s_dat_i, m1_dat_o ^ s_dat_i}, 0);
        if (own < 0) chk("rnd_we_idle", s_we_o, 0);
        else begin
            chk("rnd_adr", s_adr_o, own == 0 ? m0_adr_i : m1_adr_i);
            chk("rnd_dat", s_dat_o, own == 0 ? m0_dat_i : m1_dat_i);
            chk("rnd_sel", s_sel_o, own == 0 ? m0_sel_i : m1_sel_i);
            chk("rnd_we", s_we_o, own == 0 ? m0_we_i : m1_we_i);
        end
        if (own < 0) nown = (c[0] && c[1]) ? 1 - lst : c[0] ? 0 : c[1] ? 1 : -1;
        else if (c[own]) nown = own;
        else begin
            lst = own;
            nown = c[1 - own] ? 1 - own : -1;
        end
        hit = sstb && !s_ack_i && (wc == TO);
        wc = (nown != own || !sstb || s_ack_i || hit) ? 0 : wc + 1;
        ab = hit;
        own = nown;
    endtask

    int rise, errk;

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};

        // Alternation and ack routing table
        do_reset();
        for (int i = 0; i < 13; i++) begin
            m0_cyc_i = tbl[i].c0; m1_cyc_i = tbl[i].c1;
            m0_stb_i = tbl[i].s0; m1_stb_i = tbl[i].s1; s_ack_i = tbl[i].ack;
            #1;
            chk($sformatf("tbl%0d_gnt", i), gnt, tbl[i].gnt);
            chk($sformatf("tbl%0d_scyc", i), s_cyc_o, tbl[i].scyc);
            chk($sformatf("tbl%0d_sstb", i), s_stb_o, tbl[i].sstb);
            chk($sformatf("tbl%0d_ack", i), {m1_ack_o, m0_ack_o}, {tbl[i].a1, tbl[i].a0});
            chk($sformatf("tbl%0d_err", i), {m1_err_o, m0_err_o}, 2'b00);
            tick();
        end

        // m0 write, slave acks three cycles after strobe
        do_reset();
        m0_adr_i = 30'h0000100; m0_dat_i = 32'hDEADBEEF; m0_sel_i = 4'hF;
        m0_we_i = 1; m0_stb_i = 1; m0_cyc_i = 1;
        #1; chk("wr_idle_scyc", s_cyc_o, 0);
        tick();
        chk("wr_adr", s_adr_o, 30'h0000100);
        chk("wr_dat", s_dat_o, 32'hDEADBEEF);
        chk("wr_sel", s_sel_o, 4'hF);
        chk("wr_we", s_we_o, 1);
        chk("wr_stb", s_stb_o, 1);
        chk("wr_gnt", gnt, 2'b01);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("wr_wait_ack", m0_ack_o, 0);
        end
        tick();
        s_ack_i = 1; s_dat_i = 32'h12345678;
        #1;
        chk("wr_m0_ack", m0_ack_o, 1);
        chk("wr_m1_ack", m1_ack_o, 0);
        chk("wr_bcast", {m0_dat_o, m1_dat_o}, {32'h12345678, 32'h12345678});
        tick();
        s_ack_i = 0; m0_stb_i = 0; m0_cyc_i = 0;
        #1; chk("wr_ack_done", m0_ack_o, 0);

        // m1 locked over four beats while m0 waits
        do_reset();
        m1_cyc_i = 1;
        tick();
        m0_cyc_i = 1;
        for (int b = 0; b < 4; b++) begin
            m1_stb_i = 1; s_ack_i = 1;
            #1;
            chk("lock_gnt", gnt, 2'b10);
            chk("lock_ack", {m1_ack_o, m0_ack_o}, 2'b10);
            tick();
        end
        m1_stb_i = 0; m1_cyc_i = 0; s_ack_i = 0;
        #1; chk("lock_release_gnt", gnt, 2'b10);
        tick();
        chk("lock_handoff_gnt", gnt, 2'b01);

        // Timeout: no ack ever
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1;
        rise = -1; errk = -1;
        for (int k = 0; k < 40 && errk < 0; k++) begin
            #1;
            if (s_stb_o && rise < 0) rise = k;
            if (m0_err_o) errk = k;
            else tick();
        end
        chk("to_found", {rise >= 0, errk >= 0}, 2'b11);
        chk("to_latency", errk - rise, 9);
        chk("to_stb_low", s_stb_o, 0);
        chk("to_m1_err", m1_err_o, 0);
        s_ack_i = 1;
        #1; chk("to_late_ack", m0_ack_o, 0);
        tick();
        s_ack_i = 0;
        #1;
        chk("to_err_once", m0_err_o, 0);
        chk("to_stb_resume", s_stb_o, 1);

        // Ack exactly on the limit cycle wins
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1;
        tick();
        repeat (TO) tick();
        s_ack_i = 1;
        #1;
        chk("lim_ack", m0_ack_o, 1);
        chk("lim_err", m0_err_o, 0);
        tick();
        s_ack_i = 0;
        #1; chk("lim_no_err", m0_err_o, 0);

        // Asynchronous reset mid-burst
        do_reset();
        m1_cyc_i = 1; m1_stb_i = 1;
        tick(); tick();
        #2;
        rst_n = 0;
        #1;
        chk("arst_scyc", s_cyc_o, 0);
        chk("arst_gnt", gnt, 2'b00);
        chk("arst_out", {s_stb_o, m1_ack_o, m1_err_o}, 3'b000);
        tick();
        m0_cyc_i = 1; m0_stb_i = 0; m1_stb_i = 0;
        #2;
        rst_n = 1;
        #1; chk("arst_rel_gnt", gnt, 2'b00);
        tick();
        chk("arst_m0_prio", gnt, 2'b01);

        // Randomized traffic against the model
        do_reset();
        own = -1; lst = 1; wc = 0; ab = 0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 5) == 0) m0_cyc_i = ~m0_cyc_i;
            if ($urandom_range(0, 5) == 0) m1_cyc_i = ~m1_cyc_i;
            m0_stb_i = ($urandom_range(0, 3) != 0);
            m1_stb_i = ($urandom_range(0, 3) != 0);
            s_ack_i  = ($urandom_range(0, 6) == 0);
            m0_adr_i = 30'($urandom); m1_adr_i = 30'($urandom);
            m0_dat_i = $urandom; m1_dat_i = $urandom; s_dat_i = $urandom;
            m0_sel_i = 4'($urandom); m1_sel_i = 4'($urandom);
            m0_we_i = 1'($urandom); m1_we_i = 1'($urandom);
            #1;
            model_cycle();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
